uart_tx_frame: RTL and testbench

Parametrised UART transmitter, the next generation of the fixed 8N1 transmitter. It serialises words of configurable width with optional parity and one or two stop bits, at a baud rate set by a clock divider. Input uses a trig/ready handshake in place of a free-running trigger. It sits between on-chip producers and the serial pin `tx`.

---
 rtl/uart_tx_frame.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// Parametrised UART transmitter. Serialises DATA_BITS-wide words LSB first as
//   start(0) | data | [parity] | STOP_BITS x stop(1)
// with every bit held for exactly CLK_DIV clock cycles. Words are accepted on
// a rising edge where trig && ready.
//
// Optional feature macro: UART_TX_FIFO_EN
//   undefined : ready = FSM idle; a word is accepted and its start bit begins
//               on the same edge. Back-to-back frames are separated by one
//               idle-high clock.
//   defined   : a FIFO_DEPTH-entry FIFO sits in front of the FSM; ready = FIFO
//               not full. Queued words are sent back-to-back with no gap.
//
// Parameters
//   CLK_DIV    clock cycles per serial bit (2..65535)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//   FIFO_DEPTH FIFO entries, power of 2 >= 2 (FIFO build only)
//
// Ports
//   clk           in   clock, all state updates on the rising edge
//   rst           in   asynchronous active-low reset
//   trig          in   producer request
//   data_to_send  in   word sampled on accept
//   ready         out  block can accept a word this cycle
//   tx            out  registered serial line, idle high
//   busy          out  frame in progress or buffered data pending
// -----------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trig,
  input  logic [DATA_BITS-1:0] data_to_send,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned      BIT_W      = $clog2(DATA_BITS);
  localparam logic [15:0]      BAUD_LOAD  = 16'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_DATA  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP  = BIT_W'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY != 0);
  localparam logic             ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;     // data-bit index in DATA, stop-bit index in STOP
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;     // parity captured at load; the shifter is consumed
  logic                 tx_q, tx_d;

  logic                 word_avail;       // a word can start a frame this cycle
  logic [DATA_BITS-1:0] word;             // word that would be loaded
  logic                 load;             // frame starts on this edge (also the FIFO pop)
  logic                 bit_done;

  // ---------------------------------------------------------------------------
  // Word source
  // ---------------------------------------------------------------------------
`ifdef UART_TX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]       wr_q, rd_q;       // extra MSB tells full from empty
  logic                 empty, full, push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                 (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign push  = trig && !full;

  // NOTE: storage has no reset; only the pointers define what is valid, and
  // leaving the array out of the reset keeps it mappable to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q[PTR_W-1:0]] <= data_to_send;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (PTR_W+1)'(1);
      if (load) rd_q <= rd_q + (PTR_W+1)'(1);
    end
  end

  assign word_avail = !empty;
  assign word       = mem[rd_q[PTR_W-1:0]];
  assign ready      = !full;
  assign busy       = (state_q != IDLE) || !empty;
`else
  // Without buffering the accept edge is the load edge, so trig is only
  // honoured while the FSM is idle.
  assign word_avail = trig;
  assign word       = data_to_send;
  assign ready      = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignment so all of them
  // update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: next state and next tx level
  // tx_d is the level for the bit that begins on the coming edge, which keeps
  // the line registered without adding a cycle of latency.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    load     = 1'b0;
    bit_done = (baud_q == '0);

    if (state_q != IDLE && !bit_done) baud_d = baud_q - 16'd1;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        load = word_avail;
      end

      START: begin
        if (bit_done) begin
          state_d = DATA;
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end

      DATA: begin
        if (bit_done) begin
          baud_d  = BAUD_LOAD;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
            if (HAS_PARITY) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end

      PAR: begin
        if (bit_done) begin
          state_d = STOP;
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (bit_q == LAST_STOP) begin
`ifdef UART_TX_FIFO_EN
            // Chain straight into the next start bit: zero-gap streaming.
            load = word_avail;
`endif
            if (!load) begin
              state_d = IDLE;
              baud_d  = '0;
              bit_d   = '0;
            end
          end else begin
            bit_d  = bit_q + 1'b1;
            baud_d = BAUD_LOAD;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Common frame start from IDLE (or from STOP when buffered words wait).
    if (load) begin
      state_d = START;
      baud_d  = BAUD_LOAD;
      bit_d   = '0;
      shift_d = word;
      par_d   = (^word) ^ ODD_PARITY;
      tx_d    = 1'b0;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//
// Directed bench for uart_tx_frame. Four instances, all at CLK_DIV=4, cover
// 8N1, even parity with two stop bits, odd parity, and 7 data bits. Expected
// frames are written out by hand as {stop.., parity, data MSB..LSB, start},
// so bit i of each constant is the i-th bit on the line. Outputs are sampled
// on the falling edge, half a cycle after the rising edge that updates them.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       trig_v  [4];
  logic       tx_v    [4];
  logic       ready_v [4];
  logic       busy_v  [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_DIV(CD)) u_8n1 (
    .clk(clk), .rst(rst), .trig(trig_v[0]), .data_to_send(data),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0])
  );

  uart_tx_frame #(.CLK_DIV(CD), .PARITY(2), .STOP_BITS(2)) u_even2 (
    .clk(clk), .rst(rst), .trig(trig_v[1]), .data_to_send(data),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1])
  );

  uart_tx_frame #(.CLK_DIV(CD), .PARITY(1)) u_odd (
    .clk(clk), .rst(rst), .trig(trig_v[2]), .data_to_send(data),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2])
  );

  uart_tx_frame #(.CLK_DIV(CD), .DATA_BITS(7)) u_7bit (
    .clk(clk), .rst(rst), .trig(trig_v[3]), .data_to_send(data[6:0]),
    .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3])
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line idle, nothing pending, ready for a word.
  task automatic check_idle(input int idx, input string name);
    check({name, "_tx"},    16'(tx_v[idx]),    16'h1);
    check({name, "_busy"},  16'(busy_v[idx]),  16'h0);
    check({name, "_ready"}, 16'(ready_v[idx]), 16'h1);
  endtask

  // Called on a falling edge with the block idle. Returns on the falling edge
  // just after the start bit began.
  task automatic start_frame(input int idx, input logic [7:0] d, input bit keep);
    check($sformatf("ready_before_%0d", idx), 16'(ready_v[idx]), 16'h1);
    data        = d;
    trig_v[idx] = 1'b1;
    @(negedge clk);
    if (!keep) trig_v[idx] = 1'b0;
    check($sformatf("busy_on_accept_%0d", idx), 16'(busy_v[idx]), 16'h1);
`ifdef UART_TX_FIFO_EN
    @(negedge clk);
`endif
  endtask

  // Checks frame cycles [first, last), cycle 0 being the first start-bit
  // cycle; returns on the falling edge after cycle last-1.
  task automatic expect_frame(input int idx, input string name,
                              input logic [15:0] frame, input int first, input int last);
    for (int c = first; c < last; c++) begin
      check($sformatf("%s_c%0d_tx", name, c),   16'(tx_v[idx]),   16'(frame[c/CD]));
      check($sformatf("%s_c%0d_busy", name, c), 16'(busy_v[idx]), 16'h1);
`ifndef UART_TX_FIFO_EN
      check($sformatf("%s_c%0d_ready", name, c), 16'(ready_v[idx]), 16'h0);
`endif
      @(negedge clk);
    end
  endtask

  initial begin
    rst  = 1'b0;
    data = '0;
    for (int i = 0; i < 4; i++) trig_v[i] = 1'b0;

    // Reset values on every instance.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) check_idle(i, $sformatf("reset_%0d", i));
    rst = 1'b1;
    @(negedge clk);

    // 8N1, 0x34: 0 | 0,0,1,0,1,1,0,0 | 1 -> 40 cycles.
    start_frame(0, 8'h34, 1'b0);
    expect_frame(0, "n1_34", 16'(10'b1_00110100_0), 0, 40);
    check_idle(0, "n1_34_end");

    // Even parity, 2 stop bits, 0x34: three ones -> parity 1; stop held 8 cycles.
    start_frame(1, 8'h34, 1'b0);
    expect_frame(1, "ev2_34", 16'(12'b11_1_00110100_0), 0, 48);
    check_idle(1, "ev2_34_end");

    // Odd parity, 0xAB: five ones -> parity 0.
    start_frame(2, 8'hAB, 1'b0);
    expect_frame(2, "odd_ab", 16'(11'b1_0_10101011_0), 0, 44);
    check_idle(2, "odd_ab_end");

    // 7 data bits, 0x55: 1,0,1,0,1,0,1 then stop.
    start_frame(3, 8'h55, 1'b0);
    expect_frame(3, "d7_55", 16'(9'b1_1010101_0), 0, 36);
    check_idle(3, "d7_55_end");

    // Reset in the middle of data bit 3 (frame cycles 16..19) aborts at once.
    start_frame(0, 8'hAB, 1'b0);
    expect_frame(0, "rst_ab", 16'(10'b1_10101011_0), 0, 18);
    rst = 1'b0;
    #1;
    check_idle(0, "rst_async");
    @(negedge clk);
    check_idle(0, "rst_held");
    rst = 1'b1;
    @(negedge clk);
    check_idle(0, "rst_released");

    // Clean frame after the abort.
    start_frame(0, 8'hAA, 1'b0);
    expect_frame(0, "post_rst_aa", 16'(10'b1_10101010_0), 0, 40);
    check_idle(0, "post_rst_aa_end");

`ifndef UART_TX_FIFO_EN
    // trig held high: one idle clock between frames, and changing the input
    // word mid-frame leaves the frame in flight untouched.
    start_frame(0, 8'h34, 1'b1);
    data = 8'h0F;
    expect_frame(0, "cont_34", 16'(10'b1_00110100_0), 0, 40);
    check_idle(0, "cont_gap");
    @(negedge clk);
    trig_v[0] = 1'b0;
    expect_frame(0, "cont_0f", 16'(10'b1_00001111_0), 0, 40);
    check_idle(0, "cont_end");
`else
    // Five pushes on consecutive edges; the first starts one edge after its
    // push and frees a slot, so the fifth push fills the FIFO and a sixth
    // word offered while full is refused.
    data      = 8'hAB;
    trig_v[0] = 1'b1;
    @(negedge clk);
    check("fifo_busy_after_push", 16'(busy_v[0]), 16'h1);
    check("fifo_tx_before_start", 16'(tx_v[0]),   16'h1);
    data = 8'hAA;
    @(negedge clk);
    check("fifo_start_latency", 16'(tx_v[0]), 16'h0);
    data = 8'h34;
    @(negedge clk);
    data = 8'h12;
    @(negedge clk);
    data = 8'h55;
    @(negedge clk);
    check("fifo_full_ready", 16'(ready_v[0]), 16'h0);
    data = 8'h77;
    @(negedge clk);
    check("fifo_refused_ready", 16'(ready_v[0]), 16'h0);
    trig_v[0] = 1'b0;
    expect_frame(0, "fifo_ab", 16'(10'b1_10101011_0), 4, 40);
    expect_frame(0, "fifo_aa", 16'(10'b1_10101010_0), 0, 40);
    expect_frame(0, "fifo_34", 16'(10'b1_00110100_0), 0, 40);
    expect_frame(0, "fifo_12", 16'(10'b1_00010010_0), 0, 40);
    expect_frame(0, "fifo_55", 16'(10'b1_01010101_0), 0, 40);
    check_idle(0, "fifo_end");
    repeat (CD) @(negedge clk);
    check_idle(0, "fifo_no_extra");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
